// File: rtl/tcp_event_packetizer.sv
// Debounced multi-channel event source for the SiTCP TX byte path.
// Queues one event per channel, arbitrates round-robin and emits framed packets under TX back-pressure.
module tcp_event_packetizer #(
   parameter int unsigned NCH        = 5,
   parameter int unsigned DEB_CYCLES = 200000,
   parameter int unsigned TS_BYTES   = 4,
   parameter logic [7:0]  HDR_BYTE   = 8'hA5,
   parameter logic [7:0]  TRL_BYTE   = 8'h5A
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   input  logic [NCH-1:0] btn_in,
   input  logic           tx_full,
   output logic           tx_wr,
   output logic [7:0]     tx_data,
   output logic [NCH-1:0] pending,
   output logic [7:0]     ovf_cnt,
   output logic           busy
);
   localparam int unsigned CW  = $clog2(DEB_CYCLES) + 1;
   localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned TSW = 8 * TS_BYTES;
   localparam int unsigned BW  = $clog2(TS_BYTES) + 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [BW-1:0] TS_LAST  = BW'(TS_BYTES - 1);

   typedef enum logic [2:0] {IDLE, HDR, CHAN, SEQ, TS, TRL} state_t;

   state_t          r_state, w_state_nxt;
   logic [NCH-1:0]  r_s1, r_sync, r_deb, r_pending, w_rise, w_gnt_vec;
   logic [CW-1:0]   r_cnt [NCH];
   logic [PW-1:0]   r_ptr, w_win;
   logic [TSW-1:0]  r_ts, r_ts_lat;
   logic [BW-1:0]   r_bcnt;
   logic [7:0]      r_seq, r_ovf, r_tx_data, w_byte;
   logic            r_tx_wr, r_busy, w_found, w_grant, w_emit;
   logic [5:0]      w_drop_n;
   logic [9:0]      w_ovf_sum;

   // Two-flop synchroniser and per-channel debounce counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '0;
         r_sync <= '0;
         r_deb  <= '0;
         for (int i = 0; i < int'(NCH); i++) r_cnt[i] <= '0;
      end else begin
         r_s1   <= btn_in;
         r_sync <= r_s1;
         for (int i = 0; i < int'(NCH); i++) begin
            if (r_sync[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_LAST) begin
               r_deb[i] <= r_sync[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Rising debounced edge, i.e. the cycle the debounced state accepts a 1
   always_comb begin
      w_rise = '0;
      for (int i = 0; i < int'(NCH); i++)
         w_rise[i] = r_sync[i] & ~r_deb[i] & (r_cnt[i] == DEB_LAST);
   end

   // Round-robin search: first pending bit strictly after the pointer, with wrap
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= int'(NCH); k++) begin
         if (!w_found && r_pending[PW'((int'(r_ptr) + k) % int'(NCH))]) begin
            w_found = 1'b1;
            w_win   = PW'((int'(r_ptr) + k) % int'(NCH));
         end
      end
      w_grant   = (r_state == IDLE) && enable && w_found;
      w_gnt_vec = w_grant ? (NCH'(1) << w_win) : '0;
   end

   // Drops: new event on a still-queued channel that is not being granted now
   always_comb begin
      w_drop_n = '0;
      for (int i = 0; i < int'(NCH); i++)
         if (w_rise[i] && r_pending[i] && !w_gnt_vec[i]) w_drop_n = w_drop_n + 6'd1;
      w_ovf_sum = 10'(r_ovf) + 10'(w_drop_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_byte      = 8'h00;
      case (r_state)
         IDLE: if (w_grant) w_state_nxt = HDR;
         HDR: begin
            w_byte = HDR_BYTE;
            w_emit = !tx_full;
            if (w_emit) w_state_nxt = CHAN;
         end
         CHAN: begin
            w_byte = 8'(r_ptr);
            w_emit = !tx_full;
            if (w_emit) w_state_nxt = SEQ;
         end
         SEQ: begin
            w_byte = r_seq;
            w_emit = !tx_full;
            if (w_emit) w_state_nxt = TS;
         end
         TS: begin
            w_byte = r_ts_lat[TSW-1 -: 8];
            w_emit = !tx_full;
            if (w_emit && r_bcnt == TS_LAST) w_state_nxt = TRL;
         end
         TRL: begin
            w_byte = TRL_BYTE;
            w_emit = !tx_full;
            if (w_emit) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (!enable) begin
         w_state_nxt = IDLE;
         w_emit      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_wr   <= 1'b0;
         r_tx_data <= '0;
         r_busy    <= 1'b0;
         r_ts      <= '0;
         r_ts_lat  <= '0;
         r_bcnt    <= '0;
         r_pending <= '0;
         r_ovf     <= '0;
         r_seq     <= '0;
         r_ptr     <= PW'(NCH - 1);
      end else begin
         r_tx_wr <= w_emit;
         r_busy  <= (w_state_nxt != IDLE);
         r_ts    <= r_ts + TSW'(1);
         if (w_emit) r_tx_data <= w_byte;
         if (!enable) begin
            r_pending <= '0;
            r_seq     <= '0;
            r_ptr     <= PW'(NCH - 1);
            r_bcnt    <= '0;
         end else begin
            r_pending <= (r_pending & ~w_gnt_vec) | w_rise;
            r_ovf     <= (w_ovf_sum > 10'd255) ? 8'hFF : 8'(w_ovf_sum);
            if (w_grant) begin
               r_ptr    <= w_win;
               r_ts_lat <= r_ts;
               r_bcnt   <= '0;
            end
            // Timestamp goes out MSB first by shifting the latched copy
            if (w_emit && r_state == TS) begin
               r_ts_lat <= r_ts_lat << 8;
               r_bcnt   <= r_bcnt + BW'(1);
            end
            if (w_emit && r_state == TRL) r_seq <= r_seq + 8'd1;
         end
      end
   end

   assign tx_wr   = r_tx_wr;
   assign tx_data = r_tx_data;
   assign pending = r_pending;
   assign ovf_cnt = r_ovf;
   assign busy    = r_busy;
endmodule
